// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/control generation and the
// D/E pipeline register with load-use stall and EX flush handling.
module decode_stage #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] INSTR_D,
    input  logic [XLEN-1:0] PC_DE,
    input  logic            FLUSH_D,
    input  logic            WB_WE,
    input  logic [RA_W-1:0] WB_A,
    input  logic [XLEN-1:0] WB_D,
    output logic            STALL_FD,
    output logic            VALID_E,
    output logic            ILLEGAL_E,
    output logic [XLEN-1:0] PC_E,
    output logic [XLEN-1:0] RS1_V_E,
    output logic [XLEN-1:0] RS2_V_E,
    output logic [XLEN-1:0] IMM_E,
    output logic [RA_W-1:0] RS1_E,
    output logic [RA_W-1:0] RS2_E,
    output logic [RA_W-1:0] RD_E,
    output logic [15:0]     CTRL_E
);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic       rsvd;
        logic       jalr;
        logic       jump;
        logic       branch;
        logic       wb_en;
        logic [2:0] funct3;
        logic       mem_we;
        logic       mem_re;
        logic       src_pc;
        logic       src_imm;
        logic [3:0] alu_op;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            illegal;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_v;
        logic [XLEN-1:0] rs2_v;
        logic [XLEN-1:0] imm;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        ctrl_t           ctrl;
    } de_t;

    logic [XLEN-1:0] rf_q [REG_NUM];
    de_t             dec;
    de_t             de_d;
    de_t             de_q;
    logic            hazard;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            alt;
    logic [RA_W-1:0] rd_f;
    logic [RA_W-1:0] rs1_f;
    logic [RA_W-1:0] rs2_f;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [3:0]      alu_f3;

    assign opc   = INSTR_D[6:0];
    assign f3    = INSTR_D[14:12];
    assign alt   = INSTR_D[30];
    assign rd_f  = INSTR_D[11:7];
    assign rs1_f = INSTR_D[19:15];
    assign rs2_f = INSTR_D[24:20];

    assign imm_i = {{20{INSTR_D[31]}}, INSTR_D[31:20]};
    assign imm_s = {{20{INSTR_D[31]}}, INSTR_D[31:25], INSTR_D[11:7]};
    assign imm_b = {{19{INSTR_D[31]}}, INSTR_D[31], INSTR_D[7],
                    INSTR_D[30:25], INSTR_D[11:8], 1'b0};
    assign imm_u = {INSTR_D[31:12], 12'h000};
    assign imm_j = {{11{INSTR_D[31]}}, INSTR_D[31], INSTR_D[19:12],
                    INSTR_D[20], INSTR_D[30:21], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
        end else if (WB_WE && WB_A != '0) begin
            rf_q[WB_A] <= WB_D;
        end
    end

    always_comb begin
        alu_f3 = ALU_ADD;
        unique case (f3)
            3'd0: alu_f3 = ALU_ADD;
            3'd1: alu_f3 = ALU_SLL;
            3'd2: alu_f3 = ALU_SLT;
            3'd3: alu_f3 = ALU_SLTU;
            3'd4: alu_f3 = ALU_XOR;
            3'd5: alu_f3 = ALU_SRL;
            3'd6: alu_f3 = ALU_OR;
            3'd7: alu_f3 = ALU_AND;
        endcase
    end

    // Unused source indices stay 0 so they can never match a load's rd.
    always_comb begin
        dec = '0;
        if (INSTR_D != '0) begin
            dec.valid = 1'b1;
            dec.pc    = PC_DE;
            unique case (opc)
                OPC_LUI: begin
                    dec.imm              = imm_u;
                    dec.rd               = rd_f;
                    dec.ctrl.alu_op      = ALU_PASS;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.wb_en       = 1'b1;
                end
                OPC_AUIPC: begin
                    dec.imm              = imm_u;
                    dec.rd               = rd_f;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.src_pc      = 1'b1;
                    dec.ctrl.wb_en       = 1'b1;
                end
                OPC_JAL: begin
                    dec.imm              = imm_j;
                    dec.rd               = rd_f;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.src_pc      = 1'b1;
                    dec.ctrl.wb_en       = 1'b1;
                    dec.ctrl.jump        = 1'b1;
                end
                OPC_JALR: begin
                    dec.imm              = imm_i;
                    dec.rs1              = rs1_f;
                    dec.rd               = rd_f;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.funct3      = f3;
                    dec.ctrl.wb_en       = 1'b1;
                    dec.ctrl.jump        = 1'b1;
                    dec.ctrl.jalr        = 1'b1;
                end
                OPC_BRANCH: begin
                    dec.imm              = imm_b;
                    dec.rs1              = rs1_f;
                    dec.rs2              = rs2_f;
                    dec.ctrl.alu_op      = ALU_SUB;
                    dec.ctrl.funct3      = f3;
                    dec.ctrl.branch      = 1'b1;
                end
                OPC_LOAD: begin
                    dec.imm              = imm_i;
                    dec.rs1              = rs1_f;
                    dec.rd               = rd_f;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.mem_re      = 1'b1;
                    dec.ctrl.funct3      = f3;
                    dec.ctrl.wb_en       = 1'b1;
                end
                OPC_STORE: begin
                    dec.imm              = imm_s;
                    dec.rs1              = rs1_f;
                    dec.rs2              = rs2_f;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.mem_we      = 1'b1;
                    dec.ctrl.funct3      = f3;
                end
                OPC_OPIMM: begin
                    dec.imm              = imm_i;
                    dec.rs1              = rs1_f;
                    dec.rd               = rd_f;
                    dec.ctrl.alu_op      = (f3 == 3'd5 && alt) ? ALU_SRA : alu_f3;
                    dec.ctrl.src_imm     = 1'b1;
                    dec.ctrl.funct3      = f3;
                    dec.ctrl.wb_en       = 1'b1;
                end
                OPC_OP: begin
                    dec.rs1              = rs1_f;
                    dec.rs2              = rs2_f;
                    dec.rd               = rd_f;
                    dec.ctrl.alu_op      = alu_f3 + {3'b000, alt && (f3 == 3'd0 || f3 == 3'd5)};
                    dec.ctrl.funct3      = f3;
                    dec.ctrl.wb_en       = 1'b1;
                end
                default: dec.illegal = 1'b1;
            endcase
            dec.rs1_v = (dec.rs1 == '0) ? '0 :
                        (WB_WE && WB_A == dec.rs1) ? WB_D : rf_q[dec.rs1];
            dec.rs2_v = (dec.rs2 == '0) ? '0 :
                        (WB_WE && WB_A == dec.rs2) ? WB_D : rf_q[dec.rs2];
        end
    end

    assign hazard = de_q.valid && de_q.ctrl.mem_re && de_q.rd != '0 &&
                    (de_q.rd == dec.rs1 || de_q.rd == dec.rs2);
    assign STALL_FD = hazard && !FLUSH_D;

    assign de_d = (FLUSH_D || hazard) ? '0 : dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) de_q <= '0;
        else     de_q <= de_d;
    end

    assign VALID_E   = de_q.valid;
    assign ILLEGAL_E = de_q.illegal;
    assign PC_E      = de_q.pc;
    assign RS1_V_E   = de_q.rs1_v;
    assign RS2_V_E   = de_q.rs2_v;
    assign IMM_E     = de_q.imm;
    assign RS1_E     = de_q.rs1;
    assign RS2_E     = de_q.rs2;
    assign RD_E      = de_q.rd;
    assign CTRL_E    = de_q.ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against an arithmetic reference model
// of RV32I decode, register file and load-use stall rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] INSTR_D, PC_DE, WB_D;
    logic        FLUSH_D, WB_WE;
    logic [4:0]  WB_A;
    logic        STALL_FD, VALID_E, ILLEGAL_E;
    logic [31:0] PC_E, RS1_V_E, RS2_V_E, IMM_E;
    logic [4:0]  RS1_E, RS2_E, RD_E;
    logic [15:0] CTRL_E;

    decode_stage dut (
        .clk(clk), .rst(rst), .INSTR_D(INSTR_D), .PC_DE(PC_DE),
        .FLUSH_D(FLUSH_D), .WB_WE(WB_WE), .WB_A(WB_A), .WB_D(WB_D),
        .STALL_FD(STALL_FD), .VALID_E(VALID_E), .ILLEGAL_E(ILLEGAL_E),
        .PC_E(PC_E), .RS1_V_E(RS1_V_E), .RS2_V_E(RS2_V_E), .IMM_E(IMM_E),
        .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .CTRL_E(CTRL_E)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        il;
        logic [31:0] pc;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [15:0] ctrl;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    exp_t        m;
    logic [31:0] rf [32];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd, op);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd, op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_b(input int imm, rs2, rs1, f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, rd, op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), 7'(op)};
    endfunction
    function automatic logic [31:0] enc_j(input int imm, rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
    endfunction

    // Reference decode: immediates rebuilt by weighted sums of fields.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
        exp_t d;
        int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        int alu = 0, simm = 0, spc = 0, re = 0, we = 0, wb = 0;
        int br = 0, jp = 0, jr = 0, usef3 = 0;
        int f3, t, lo, ii, is, ib, ij;
        f3 = int'(ins[14:12]);
        t  = ins;
        ii = t >>> 20;
        t  = t >>> 25;
        lo = int'(ins[11:7]);
        is = t * 32 + lo;
        ib = (ins[31] ? -4096 : 0) + 2048 * int'(ins[7]) +
             32 * int'(ins[30:25]) + 2 * int'(ins[11:8]);
        ij = (ins[31] ? -(1 << 20) : 0) + 4096 * int'(ins[19:12]) +
             2048 * int'(ins[20]) + 2 * int'(ins[30:21]);
        d = '0;
        if (ins == 32'd0) return d;
        d.v  = 1'b1;
        d.pc = pc;
        case (ins[6:0])
            7'h37: begin d.imm = ins & 32'hFFFFF000; d.rd = ins[11:7];
                         alu = 10; simm = 1; wb = 1; end
            7'h17: begin d.imm = ins & 32'hFFFFF000; d.rd = ins[11:7];
                         simm = 1; spc = 1; wb = 1; end
            7'h6F: begin d.imm = ij; d.rd = ins[11:7];
                         simm = 1; spc = 1; wb = 1; jp = 1; end
            7'h67: begin d.imm = ii; d.r1 = ins[19:15]; d.rd = ins[11:7];
                         simm = 1; wb = 1; jp = 1; jr = 1; usef3 = 1; end
            7'h63: begin d.imm = ib; d.r1 = ins[19:15]; d.r2 = ins[24:20];
                         alu = 1; br = 1; usef3 = 1; end
            7'h03: begin d.imm = ii; d.r1 = ins[19:15]; d.rd = ins[11:7];
                         simm = 1; re = 1; wb = 1; usef3 = 1; end
            7'h23: begin d.imm = is; d.r1 = ins[19:15]; d.r2 = ins[24:20];
                         simm = 1; we = 1; usef3 = 1; end
            7'h13: begin d.imm = ii; d.r1 = ins[19:15]; d.rd = ins[11:7];
                         alu = alu_tab[f3] + ((f3 == 5 && ins[30]) ? 1 : 0);
                         simm = 1; wb = 1; usef3 = 1; end
            7'h33: begin d.r1 = ins[19:15]; d.r2 = ins[24:20]; d.rd = ins[11:7];
                         alu = alu_tab[f3] + (((f3 == 0 || f3 == 5) && ins[30]) ? 1 : 0);
                         wb = 1; usef3 = 1; end
            default: begin d.il = 1'b1; return d; end
        endcase
        d.ctrl = 16'(alu + 16 * simm + 32 * spc + 64 * re + 128 * we +
                     256 * (usef3 != 0 ? f3 : 0) + 2048 * wb + 4096 * br +
                     8192 * jp + 16384 * jr);
        return d;
    endfunction

    function automatic logic [31:0] rdv(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return rf[a];
    endfunction

    task automatic cmp_all();
        check("valid", {31'd0, VALID_E}, {31'd0, m.v});
        check("illegal", {31'd0, ILLEGAL_E}, {31'd0, m.il});
        check("pc", PC_E, m.pc);
        check("rs1_v", RS1_V_E, m.v1);
        check("rs2_v", RS2_V_E, m.v2);
        check("imm", IMM_E, m.imm);
        check("rs1", {27'd0, RS1_E}, {27'd0, m.r1});
        check("rs2", {27'd0, RS2_E}, {27'd0, m.r2});
        check("rd", {27'd0, RD_E}, {27'd0, m.rd});
        check("ctrl", {16'd0, CTRL_E}, {16'd0, m.ctrl});
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, output logic stl);
        exp_t n;
        logic es;
        INSTR_D = ins; PC_DE = pc; FLUSH_D = fl;
        WB_WE = we; WB_A = wa; WB_D = wd;
        n  = ref_dec(ins, pc);
        es = !fl && m.v && m.ctrl[6] && m.rd != 5'd0 &&
             (m.rd == n.r1 || m.rd == n.r2);
        #1;
        check("stall", {31'd0, STALL_FD}, {31'd0, es});
        if (n.v && !n.il) begin
            n.v1 = rdv(n.r1, we, wa, wd);
            n.v2 = rdv(n.r2, we, wa, wd);
        end
        if (fl || es) n = '0;
        @(posedge clk);
        if (we && wa != 5'd0) rf[wa] = wd;
        m = n;
        #1;
        cmp_all();
        stl = es;
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        m = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        cmp_all();
        @(posedge clk);
        #1;
        cmp_all();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] gen();
        logic [31:0] ins;
        logic [6:0]  ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h13, 7'h33};
        logic [6:0]  bads [4] = '{7'h7F, 7'h0F, 7'h73, 7'h2F};
        int k;
        k = $urandom_range(0, 11);
        ins = $urandom;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        if (k < 9)        ins[6:0] = ops[k];
        else if (k == 9)  ins[6:0] = 7'h03;
        else if (k == 10) ins[6:0] = bads[$urandom_range(0, 3)];
        else              ins = 32'd0;
        return ins;
    endfunction

    initial begin
        logic        s;
        logic [31:0] ins, pc;
        m = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst = 1'b1;
        INSTR_D = enc_i(5, 0, 0, 1, 7'h13);
        PC_DE = 32'h0; FLUSH_D = 1'b0;
        WB_WE = 1'b0; WB_A = 5'd0; WB_D = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp_all();
        check("rst_stall", {31'd0, STALL_FD}, 32'd0);
        rst = 1'b0;

        step(enc_i(5, 0, 0, 1, 7'h13), 32'h100, 0, 0, 0, 0, s);
        check("t1_imm", IMM_E, 32'd5);
        check("t1_rd", {27'd0, RD_E}, 32'd1);
        check("t1_ctrl", {16'd0, CTRL_E}, 32'h0810);

        step(enc_r(0, 0, 5, 0, 6, 7'h33), 32'h104, 0, 1, 5, 32'hDEADBEEF, s);
        check("t2_bypass", RS1_V_E, 32'hDEADBEEF);
        step(enc_r(0, 0, 0, 0, 7, 7'h33), 32'h108, 0, 1, 0, 32'd7, s);
        check("t2_x0", RS1_V_E, 32'd0);
        step(enc_r(0, 0, 5, 0, 8, 7'h33), 32'h10C, 0, 0, 0, 0, s);
        check("t2_commit", RS1_V_E, 32'hDEADBEEF);

        step(enc_i(0, 2, 2, 3, 7'h03), 32'h110, 0, 0, 0, 0, s);
        step(enc_r(0, 1, 3, 0, 4, 7'h33), 32'h114, 0, 0, 0, 0, s);
        check("t3_stall", {31'd0, s}, 32'd1);
        check("t3_bubble", {31'd0, VALID_E}, 32'd0);
        step(enc_r(0, 1, 3, 0, 4, 7'h33), 32'h114, 0, 0, 0, 0, s);
        check("t3_nostall", {31'd0, s}, 32'd0);
        check("t3_add_rd", {27'd0, RD_E}, 32'd4);

        step(enc_i(0, 2, 2, 3, 7'h03), 32'h118, 0, 0, 0, 0, s);
        step(enc_b(-8, 0, 3, 0), 32'h11C, 1, 0, 0, 0, s);
        check("t4_stall", {31'd0, s}, 32'd0);
        check("t4_valid", {31'd0, VALID_E}, 32'd0);

        step(enc_b(-8, 2, 1, 0), 32'h120, 0, 0, 0, 0, s);
        check("t5_beq", IMM_E, 32'hFFFFFFF8);
        step(enc_u(32'h12345, 9, 7'h37), 32'h124, 0, 0, 0, 0, s);
        check("t5_lui", IMM_E, 32'h12345000);
        step(enc_j(2048, 1), 32'h128, 0, 0, 0, 0, s);
        check("t5_jal", IMM_E, 32'h00000800);

        step(32'h0000007F, 32'h12C, 0, 0, 0, 0, s);
        check("t6_valid", {31'd0, VALID_E}, 32'd1);
        check("t6_illegal", {31'd0, ILLEGAL_E}, 32'd1);
        check("t6_ctrl", {16'd0, CTRL_E}, 32'd0);
        step(32'h0, 32'h130, 0, 0, 0, 0, s);
        check("t6_bubble", {31'd0, VALID_E}, 32'd0);

        s = 1'b0;
        pc = 32'h200;
        ins = 32'd0;
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                mid_reset();
                s = 1'b0;
            end
            if (!s) begin
                pc += 32'd4;
                ins = gen();
            end
            step(ins, pc, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom, s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
